// File: rtl/axil_pkg.sv
// Shared definitions for the queued AXI4-Lite master: response codes, FSM encoding
// and the packing of a command word {write, addr, wdata, wstrb}.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_WB   = 3'd2,
    ST_RA   = 3'd3,
    ST_RD   = 3'd4,
    ST_RSP  = 3'd5
  } state_t;

  // Strobes occupy the low bits of the command word, so their offset is zero.
  function automatic int cmd_wdata_lsb(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int cmd_addr_lsb(input int data_w);
    return data_w + data_w / 8;
  endfunction

  function automatic int cmd_write_bit(input int addr_w, input int data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/axil_master_queued_if.sv
// Command, response, status and AXI4-Lite bus signals of the queued master.
interface axil_master_queued_if #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LVL_W  = $clog2(CMD_DEPTH) + 1;

  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;
  logic              rsp_valid, rsp_ready, rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [LVL_W-1:0]  q_level;
  logic              busy;

  logic              AWVALID, AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              WVALID, WREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              BVALID, BREADY;
  logic [1:0]        BRESP;
  logic              ARVALID, ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              RVALID, RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, q_level, busy,
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, q_level, busy,
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axil_cmd_fifo.sv
// Synchronous command FIFO with async clear, registered full/empty/level and a
// registered read port loaded on pop.
module axil_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   LVL_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [PTR_W:0]   r_level, w_level_n;
  logic             r_full, r_empty;
  logic [WIDTH-1:0] r_data;
  logic             w_do_push, w_do_pop;

  assign w_do_push = i_push && !r_full;
  assign w_do_pop  = i_pop && !r_empty;

  always_comb begin
    w_level_n = r_level;
    if (w_do_push && !w_do_pop)      w_level_n = r_level + LVL_ONE;
    else if (w_do_pop && !w_do_push) w_level_n = r_level - LVL_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_data  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
        r_data <= r_mem[r_rptr];
      end
      r_level <= w_level_n;
      r_full  <= (w_level_n == LVL_FULL);
      r_empty <= (w_level_n == '0);
    end
  end

  assign o_data  = r_data;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;
endmodule

// File: rtl/axil_master_queued.sv
// AXI4-Lite master that executes queued read/write commands one at a time, in order,
// and returns each response on a valid/ready port.
module axil_master_queued
  import axil_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4
) (
  input  logic ACLK,
  input  logic ARESETN,
  axil_master_queued_if.master bus
);
  localparam int STRB_W    = DATA_W / 8;
  localparam int LVL_W     = $clog2(CMD_DEPTH) + 1;
  localparam int WDATA_LSB = cmd_wdata_lsb(DATA_W);
  localparam int ADDR_LSB  = cmd_addr_lsb(DATA_W);
  localparam int WRITE_BIT = cmd_write_bit(ADDR_W, DATA_W);
  localparam int CMD_W     = WRITE_BIT + 1;

  logic [CMD_W-1:0] w_cmd_in, w_cmd_out;
  logic             w_push, w_pop, w_full, w_empty;
  logic [LVL_W-1:0] w_level;

  state_t            r_state, w_state_n;
  logic              r_pend, w_pend_n;
  logic              r_awvalid, w_awvalid_n, r_wvalid, w_wvalid_n, r_bready, w_bready_n;
  logic              r_arvalid, w_arvalid_n, r_rready, w_rready_n;
  logic              r_rsp_valid, w_rsp_valid_n, r_rsp_write, w_rsp_write_n;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic [DATA_W-1:0] r_wdata, w_wdata_n, r_rdata, w_rdata_n;
  logic [STRB_W-1:0] r_wstrb, w_wstrb_n;
  logic [1:0]        r_resp, w_resp_n;

  assign w_cmd_in = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_wstrb};
  assign w_push   = bus.cmd_valid && !w_full;

  axil_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .i_clk   (ACLK),
    .i_rst_n (ARESETN),
    .i_push  (w_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_cmd_out),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= ST_IDLE;
    else          r_state <= w_state_n;
  end

  // In IDLE a pop loads the FIFO read register; the following cycle (r_pend) latches it.
  always_comb begin
    w_state_n     = r_state;
    w_pop         = 1'b0;
    w_pend_n      = r_pend;
    w_awvalid_n   = r_awvalid;
    w_wvalid_n    = r_wvalid;
    w_bready_n    = r_bready;
    w_arvalid_n   = r_arvalid;
    w_rready_n    = r_rready;
    w_rsp_valid_n = r_rsp_valid;
    w_rsp_write_n = r_rsp_write;
    w_addr_n      = r_addr;
    w_wdata_n     = r_wdata;
    w_wstrb_n     = r_wstrb;
    w_rdata_n     = r_rdata;
    w_resp_n      = r_resp;
    case (r_state)
      ST_IDLE: begin
        if (r_pend) begin
          w_pend_n  = 1'b0;
          w_addr_n  = w_cmd_out[ADDR_LSB +: ADDR_W];
          w_wdata_n = w_cmd_out[WDATA_LSB +: DATA_W];
          w_wstrb_n = w_cmd_out[STRB_W-1:0];
          if (w_cmd_out[WRITE_BIT]) begin
            w_awvalid_n = 1'b1;
            w_wvalid_n  = 1'b1;
            w_state_n   = ST_WR;
          end else begin
            w_arvalid_n = 1'b1;
            w_state_n   = ST_RA;
          end
        end else if (!w_empty) begin
          w_pop    = 1'b1;
          w_pend_n = 1'b1;
        end
      end
      ST_WR: begin
        if (r_awvalid && bus.AWREADY) w_awvalid_n = 1'b0;
        if (r_wvalid && bus.WREADY)   w_wvalid_n  = 1'b0;
        if (!w_awvalid_n && !w_wvalid_n) begin
          w_bready_n = 1'b1;
          w_state_n  = ST_WB;
        end
      end
      ST_WB: begin
        if (bus.BVALID) begin
          w_bready_n    = 1'b0;
          w_resp_n      = bus.BRESP;
          w_rdata_n     = '0;
          w_rsp_write_n = 1'b1;
          w_rsp_valid_n = 1'b1;
          w_state_n     = ST_RSP;
        end
      end
      ST_RA: begin
        if (bus.ARREADY) begin
          w_arvalid_n = 1'b0;
          w_rready_n  = 1'b1;
          w_state_n   = ST_RD;
        end
      end
      ST_RD: begin
        if (bus.RVALID) begin
          w_rready_n    = 1'b0;
          w_resp_n      = bus.RRESP;
          w_rdata_n     = bus.RDATA;
          w_rsp_write_n = 1'b0;
          w_rsp_valid_n = 1'b1;
          w_state_n     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_n = 1'b0;
          w_state_n     = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_pend      <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rdata     <= '0;
      r_resp      <= RESP_OKAY;
    end else begin
      r_pend      <= w_pend_n;
      r_awvalid   <= w_awvalid_n;
      r_wvalid    <= w_wvalid_n;
      r_bready    <= w_bready_n;
      r_arvalid   <= w_arvalid_n;
      r_rready    <= w_rready_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_rsp_write <= w_rsp_write_n;
      r_addr      <= w_addr_n;
      r_wdata     <= w_wdata_n;
      r_wstrb     <= w_wstrb_n;
      r_rdata     <= w_rdata_n;
      r_resp      <= w_resp_n;
    end
  end

  assign bus.cmd_ready = !w_full;
  assign bus.q_level   = w_level;
  assign bus.busy      = (r_state != ST_IDLE) || r_pend || !w_empty;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_write = r_rsp_write;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_resp  = r_resp;
  assign bus.AWVALID   = r_awvalid;
  assign bus.AWADDR    = r_addr;
  assign bus.AWPROT    = 3'b000;
  assign bus.WVALID    = r_wvalid;
  assign bus.WDATA     = r_wdata;
  assign bus.WSTRB     = r_wstrb;
  assign bus.BREADY    = r_bready;
  assign bus.ARVALID   = r_arvalid;
  assign bus.ARADDR    = r_addr;
  assign bus.ARPROT    = 3'b000;
  assign bus.RREADY    = r_rready;
endmodule

// File: tb/tb_axil_master_queued.sv
// Scoreboard bench for axil_master_queued with a configurable-latency AXI-Lite slave.
module tb_axil_master_queued;
  import axil_pkg::*;

  localparam int AW = 32, DW = 32, DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_master_queued_if #(.ADDR_W(AW), .DATA_W(DW), .CMD_DEPTH(DEPTH)) bus ();

  axil_master_queued #(.ADDR_W(AW), .DATA_W(DW), .CMD_DEPTH(DEPTH)) dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .bus     (bus)
  );

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit stall = 1'b0;
  int aw_lat = 0, w_lat = 0, ar_lat = 0, rsp_hold = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, b_cnt = 0;
  int push_cyc = 0, rsp_rise_cyc = 0, wr_hs_cyc = 0, ar_rise_cyc = 0;
  bit rsp_prev = 1'b0, ar_prev = 1'b0;

  logic [34:0] exp_rsp_q [$];   // {write, resp, rdata}
  logic [31:0] exp_aw_q  [$];
  logic [35:0] exp_w_q   [$];   // {strb, data}
  logic [31:0] exp_ar_q  [$];
  logic [1:0]  bresp_q   [$];
  logic [33:0] r_q       [$];   // {resp, data}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor / scoreboard
  initial begin
    logic [34:0] e;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      if (bus.rsp_valid) begin
        if (!rsp_prev) rsp_rise_cyc = cyc;
        if (exp_rsp_q.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
        else if (rsp_hold > 0) rsp_hold--;
        else begin
          e = exp_rsp_q.pop_front();
          chk("rsp_write", bus.rsp_write, e[34]);
          chk("rsp_resp", bus.rsp_resp, e[33:32]);
          chk("rsp_rdata", bus.rsp_rdata, e[31:0]);
          if (e[34]) wr_hs_cyc = cyc;
          bus.rsp_ready = 1'b1;
        end
      end
      rsp_prev = bus.rsp_valid;
    end
  end

  initial begin
    bus.AWREADY = 1'b0;
    forever begin
      @(negedge clk);
      bus.AWREADY = 1'b0;
      if (bus.AWVALID && !stall) begin
        if (aw_cnt >= aw_lat) begin
          bus.AWREADY = 1'b1; aw_cnt = 0; aw_hs++;
          if (exp_aw_q.size() == 0) chk("aw_unexpected", bus.AWVALID, 0);
          else chk("awaddr", bus.AWADDR, exp_aw_q.pop_front());
        end else begin
          aw_cnt++;
          if (exp_aw_q.size() != 0) chk("awaddr_stable", bus.AWADDR, exp_aw_q[0]);
        end
      end
    end
  end

  initial begin
    bus.WREADY = 1'b0;
    forever begin
      @(negedge clk);
      bus.WREADY = 1'b0;
      if (bus.WVALID && !stall) begin
        if (w_cnt >= w_lat) begin
          bus.WREADY = 1'b1; w_cnt = 0; w_hs++;
          if (exp_w_q.size() == 0) chk("w_unexpected", bus.WVALID, 0);
          else chk("wdata_wstrb", {bus.WSTRB, bus.WDATA}, exp_w_q.pop_front());
        end else begin
          w_cnt++;
          if (exp_w_q.size() != 0) chk("wdata_stable", {bus.WSTRB, bus.WDATA}, exp_w_q[0]);
        end
      end
    end
  end

  initial begin
    bus.BVALID = 1'b0; bus.BRESP = RESP_OKAY;
    forever begin
      @(negedge clk);
      if (bus.BVALID) begin
        bus.BVALID = 1'b0; b_cnt++;
      end else if (bus.BREADY && !stall && aw_hs > b_cnt && w_hs > b_cnt) begin
        bus.BVALID = 1'b1;
        bus.BRESP  = (bresp_q.size() != 0) ? bresp_q.pop_front() : RESP_OKAY;
      end
    end
  end

  initial begin
    bus.ARREADY = 1'b0;
    forever begin
      @(negedge clk);
      bus.ARREADY = 1'b0;
      if (bus.ARVALID && !ar_prev) ar_rise_cyc = cyc;
      ar_prev = bus.ARVALID;
      if (bus.ARVALID && !stall) begin
        if (ar_cnt >= ar_lat) begin
          bus.ARREADY = 1'b1; ar_cnt = 0; ar_hs++;
          if (exp_ar_q.size() == 0) chk("ar_unexpected", bus.ARVALID, 0);
          else chk("araddr", bus.ARADDR, exp_ar_q.pop_front());
        end else begin
          ar_cnt++;
          if (exp_ar_q.size() != 0) chk("araddr_stable", bus.ARADDR, exp_ar_q[0]);
        end
      end
    end
  end

  initial begin
    logic [33:0] r;
    bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = RESP_OKAY;
    forever begin
      @(negedge clk);
      if (bus.RVALID) bus.RVALID = 1'b0;
      else if (bus.RREADY && !stall) begin
        r = (r_q.size() != 0) ? r_q.pop_front() : 34'h0;
        bus.RVALID = 1'b1;
        bus.RRESP  = r[33:32];
        bus.RDATA  = r[31:0];
      end
    end
  end

  // For reads, data is what the slave returns and strb is unused.
  task automatic push_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp);
    int t = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
    bus.cmd_wdata = data; bus.cmd_wstrb = strb;
    while (!bus.cmd_ready && t < 200) begin @(negedge clk); t++; end
    if (!bus.cmd_ready) chk("cmd_accept_timeout", bus.cmd_ready, 1);
    else begin
      push_cyc = cyc;
      if (wr) begin
        exp_rsp_q.push_back({1'b1, resp, 32'h0});
        exp_aw_q.push_back(addr);
        exp_w_q.push_back({strb, data});
        bresp_q.push_back(resp);
      end else begin
        exp_rsp_q.push_back({1'b0, resp, data});
        exp_ar_q.push_back(addr);
        r_q.push_back({resp, data});
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_rsp_q.size() != 0 || bus.busy) && t < 500) begin @(negedge clk); t++; end
    chk(name, (exp_rsp_q.size() == 0 && !bus.busy), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, w0, r0, t;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.cmd_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", bus.AWVALID, 0);
    chk("rst_wvalid", bus.WVALID, 0);
    chk("rst_arvalid", bus.ARVALID, 0);
    chk("rst_bready", bus.BREADY, 0);
    chk("rst_rready", bus.RREADY, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_q_level", bus.q_level, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // single write, minimum latency
    a0 = aw_hs; w0 = w_hs;
    push_cmd(1, 32'h10, 32'hDEADBEEF, 4'hF, RESP_OKAY);
    wait_idle("t1_done");
    chk("t1_aw_once", aw_hs - a0, 1);
    chk("t1_w_once", w_hs - w0, 1);
    chk("t1_latency", rsp_rise_cyc - push_cyc, 5);
    chk("prot_zero", {bus.AWPROT, bus.ARPROT}, 0);

    // read with delayed ARREADY and a held response
    ar_lat = 3; rsp_hold = 2; r0 = ar_hs;
    push_cmd(0, 32'h20, 32'h12345678, 4'h0, RESP_OKAY);
    wait_idle("t2_done");
    chk("t2_ar_once", ar_hs - r0, 1);
    ar_lat = 0;

    // W before AW, then AW before W
    aw_lat = 4; w_lat = 0; a0 = aw_hs; w0 = w_hs;
    push_cmd(1, 32'h30, 32'hA5A5A5A5, 4'h3, RESP_OKAY);
    wait_idle("t3a_done");
    chk("t3a_aw_once", aw_hs - a0, 1);
    chk("t3a_w_once", w_hs - w0, 1);
    aw_lat = 0; w_lat = 4; a0 = aw_hs; w0 = w_hs;
    push_cmd(1, 32'h34, 32'h5A5A5A5A, 4'hC, RESP_OKAY);
    wait_idle("t3b_done");
    chk("t3b_aw_once", aw_hs - a0, 1);
    chk("t3b_w_once", w_hs - w0, 1);
    w_lat = 0;

    // fill the queue while the slave is stalled
    stall = 1'b1;
    push_cmd(1, 32'h100, 32'h11111111, 4'hF, RESP_OKAY);
    push_cmd(0, 32'h104, 32'h22222222, 4'h0, RESP_OKAY);
    push_cmd(1, 32'h108, 32'h33333333, 4'h1, RESP_OKAY);
    push_cmd(0, 32'h10C, 32'h44444444, 4'h0, RESP_DECERR);
    push_cmd(1, 32'h110, 32'h55555555, 4'hF, RESP_EXOKAY);
    repeat (2) @(negedge clk);
    chk("t4_level_full", bus.q_level, 4);
    chk("t4_ready_low", bus.cmd_ready, 0);
    chk("t4_busy", bus.busy, 1);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'hBAD;
    repeat (3) begin
      @(negedge clk);
      chk("t4_no_bypass", bus.cmd_ready, 0);
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t4_level_held", bus.q_level, 4);
    stall = 1'b0;
    wait_idle("t4_drain");

    // error response followed by an undelayed read
    push_cmd(1, 32'h40, 32'h0F0F0F0F, 4'hF, RESP_SLVERR);
    push_cmd(0, 32'h44, 32'hCAFEF00D, 4'h0, RESP_OKAY);
    wait_idle("t5_done");
    chk("t5_read_gap", ar_rise_cyc - wr_hs_cyc, 3);

    // reset while a write is outstanding
    stall = 1'b1;
    push_cmd(1, 32'h200, 32'h77777777, 4'hF, RESP_OKAY);
    t = 0;
    while (!bus.AWVALID && t < 20) begin @(negedge clk); t++; end
    chk("t6_awvalid_up", bus.AWVALID, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_awvalid", bus.AWVALID, 0);
    chk("t6_rst_wvalid", bus.WVALID, 0);
    chk("t6_rst_q_level", bus.q_level, 0);
    chk("t6_rst_rsp_valid", bus.rsp_valid, 0);
    chk("t6_rst_busy", bus.busy, 0);
    exp_rsp_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
    exp_ar_q.delete(); bresp_q.delete(); r_q.delete();
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_hs = 0; w_hs = 0; b_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_rsp", bus.rsp_valid, 0);
    end
    push_cmd(0, 32'h300, 32'h0BADF00D, 4'h0, RESP_EXOKAY);
    push_cmd(1, 32'h304, 32'h89ABCDEF, 4'h6, RESP_OKAY);
    wait_idle("t6_after_reset");

    chk("sb_drained", exp_rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
